multiword_add_seq: RTL



---
 rtl/multiword_add_seq_pkg.sv | 19 +
 rtl/multiword_add_seq_rca.sv | 23 ++
 rtl/multiword_add_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer:
// FSM state encoding and an elaboration-time log2 helper.
package multiword_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/multiword_add_seq_rca.sv
// N-bit ripple-carry adder slice; the per-cycle datapath of the sequencer.
module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ c[gi];
    assign c[gi+1]   = (a_i[gi] & b_i[gi]) | (c[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = c[N];

endmodule

// File: rtl/multiword_add_seq.sv
// W-bit add/subtract built from one N-bit ripple slice reused over WORDS cycles,
// least significant slice first, with the carry held in a register between cycles.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow,
  output logic                 busy
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     slice_a, slice_b, slice_sum;
  logic             slice_cout;

  assign slice_a = a_q[idx_q*N +: N];
  assign slice_b = b_q[idx_q*N +: N];

  ripple_carry_adder #(.N(N)) u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so the inversion and the +1 happen at capture.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q*N +: N] = slice_sum;
        carry_d             = slice_cout;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          valid_d = 1'b1;
          cout_d  = slice_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign sum       = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
